branch_predictor_ctrl: RTL and testbench

//  Front-end controller for the two-bit saturating-counter table: owns PC tags, valid bits and

---
 rtl/branch_predictor_ctrl.sv | 147 ++++++++++++++
 tb/tb_branch_predictor_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_ctrl.sv
// Front-end controller for a two-bit saturating-counter predictor table.
// Holds PC tags, valid bits and targets; trains hits and allocates slots on taken misses.
module branch_predictor_ctrl #(
  parameter int ENTRIES = 4,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic            ctr_get,
  output logic [7:0]      ctr_get_index,
  input  logic            ctr_prediction,
  output logic            ctr_set,
  output logic [7:0]      ctr_set_index,
  output logic            ctr_feedback,
  output logic            ctr_reset,
  output logic [7:0]      ctr_reset_index
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, ALLOC, TRAIN} state_t;

  state_t             state_reg;
  logic [PC_W-1:0]    tag_reg    [ENTRIES];
  logic [PC_W-1:0]    target_reg [ENTRIES];
  logic [ENTRIES-1:0] valid_reg;
  logic [IDX_W-1:0]   victim_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic               pred_valid_reg;
  logic               pred_taken_reg;
  logic [PC_W-1:0]    pred_target_reg;

  logic [ENTRIES-1:0] lk_match;
  logic [ENTRIES-1:0] up_match;
  logic               lk_hit;
  logic               up_hit;
  logic [IDX_W-1:0]   lk_idx;
  logic [IDX_W-1:0]   up_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim_next;
  logic [IDX_W-1:0]   ptr_next;
  logic               upd_fire;
  logic               idle_train;
  logic               train_phase;
  logic               alloc_phase;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_cmp
      assign lk_match[gi] = valid_reg[gi] && (tag_reg[gi] == lookup_pc);
      assign up_match[gi] = valid_reg[gi] && (tag_reg[gi] == upd_pc);
    end
  endgenerate

  always_comb begin
    lk_idx     = '0;
    up_idx     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lk_match[i]) lk_idx = IDX_W'(i);
      if (up_match[i]) up_idx = IDX_W'(i);
    end
    // Descending scan so the lowest-index free slot wins.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign lk_hit      = |lk_match;
  assign up_hit      = |up_match;
  assign victim_next = free_found ? free_idx : ptr_reg;
  assign ptr_next    = (ptr_reg == IDX_W'(ENTRIES - 1)) ? '0 : ptr_reg + 1'b1;

  assign upd_ready   = (state_reg == IDLE) && !reset;
  assign upd_fire    = upd_valid && upd_ready;
  assign idle_train  = upd_fire && up_hit;
  assign train_phase = (state_reg == TRAIN) && !reset;
  assign alloc_phase = (state_reg == ALLOC) && !reset;

  assign ctr_get         = lookup_valid;
  assign ctr_get_index   = 8'(lk_idx);
  assign ctr_set         = idle_train || train_phase;
  assign ctr_set_index   = train_phase ? 8'(victim_reg) : (idle_train ? 8'(up_idx) : 8'd0);
  assign ctr_feedback    = train_phase ? 1'b1 : (idle_train ? upd_taken : 1'b0);
  assign ctr_reset       = alloc_phase;
  assign ctr_reset_index = alloc_phase ? 8'(victim_reg) : 8'd0;

  assign pred_valid  = pred_valid_reg;
  assign pred_taken  = pred_taken_reg;
  assign pred_target = pred_target_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      valid_reg       <= '0;
      victim_reg      <= '0;
      ptr_reg         <= '0;
      pred_valid_reg  <= 1'b0;
      pred_taken_reg  <= 1'b0;
      pred_target_reg <= '0;
    end else begin
      pred_valid_reg  <= lookup_valid;
      pred_taken_reg  <= lk_hit && ctr_prediction;
      pred_target_reg <= lk_hit ? target_reg[lk_idx] : '0;
      case (state_reg)
        IDLE: begin
          if (upd_fire && !up_hit && upd_taken) begin
            victim_reg             <= victim_next;
            valid_reg[victim_next] <= 1'b1;
            if (!free_found) ptr_reg <= ptr_next;
            state_reg <= ALLOC;
          end
        end
        ALLOC:   state_reg <= TRAIN;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag/target storage carries no reset; valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (!reset && upd_fire) begin
      if (up_hit) begin
        if (upd_taken) target_reg[up_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_reg[victim_next]    <= upd_pc;
        target_reg[victim_next] <= upd_target;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl with a small two-bit counter table model.
module tb_branch_predictor_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        ctr_get;
  logic [7:0]  ctr_get_index;
  logic        ctr_prediction;
  logic        ctr_set;
  logic [7:0]  ctr_set_index;
  logic        ctr_feedback;
  logic        ctr_reset;
  logic [7:0]  ctr_reset_index;

  int checks = 0;
  int errors = 0;

  logic [1:0] cnt [256];

  always #5 clk = ~clk;

  branch_predictor_ctrl #(.ENTRIES(4), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .ctr_get(ctr_get), .ctr_get_index(ctr_get_index), .ctr_prediction(ctr_prediction),
    .ctr_set(ctr_set), .ctr_set_index(ctr_set_index), .ctr_feedback(ctr_feedback),
    .ctr_reset(ctr_reset), .ctr_reset_index(ctr_reset_index)
  );

  // External counter table: reset to weakly-not-taken, saturating train.
  assign ctr_prediction = cnt[ctr_get_index][1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) cnt[i] <= 2'b01;
    end else if (ctr_reset) begin
      cnt[ctr_reset_index] <= 2'b01;
    end else if (ctr_set) begin
      if (ctr_feedback && cnt[ctr_set_index] != 2'b11)
        cnt[ctr_set_index] <= cnt[ctr_set_index] + 2'b01;
      else if (!ctr_feedback && cnt[ctr_set_index] != 2'b00)
        cnt[ctr_set_index] <= cnt[ctr_set_index] - 2'b01;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_tgt);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    step();
    lookup_valid = 1'b0;
    #1;
    check("pred_valid", 32'(pred_valid), 32'd1);
    check("pred_taken", 32'(pred_taken), 32'(exp_taken));
    check("pred_target", pred_target, exp_tgt);
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [31:0] tgt, input logic [7:0] victim);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = 1'b1;
    upd_target = tgt;
    #1;
    check("alloc_ready0", 32'(upd_ready), 32'd1);
    check("alloc_noset0", 32'(ctr_set), 32'd0);
    step();
    upd_valid = 1'b0;
    #1;
    check("alloc_ready1", 32'(upd_ready), 32'd0);
    check("alloc_reset", 32'(ctr_reset), 32'd1);
    check("alloc_reset_idx", 32'(ctr_reset_index), 32'(victim));
    check("alloc_noset1", 32'(ctr_set), 32'd0);
    check("alloc_setidx0", 32'(ctr_set_index), 32'd0);
    step();
    #1;
    check("train_ready", 32'(upd_ready), 32'd0);
    check("train_set", 32'(ctr_set), 32'd1);
    check("train_set_idx", 32'(ctr_set_index), 32'(victim));
    check("train_fb", 32'(ctr_feedback), 32'd1);
    check("train_noreset", 32'(ctr_reset), 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    step();
    step();
    check("rst_ready", 32'(upd_ready), 32'd0);
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_set", 32'(ctr_set), 32'd0);
    check("rst_reset", 32'(ctr_reset), 32'd0);
    reset = 1'b0;

    // Lookup on empty table.
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    #1;
    check("get", 32'(ctr_get), 32'd1);
    check("get_idx_miss", 32'(ctr_get_index), 32'd0);
    lookup(32'h100, 1'b0, 32'h0);
    check("idle_ready", 32'(upd_ready), 32'd1);

    // First allocation, then it predicts taken.
    alloc(32'h100, 32'h200, 8'd0);
    check("post_alloc_ready", 32'(upd_ready), 32'd1);
    lookup(32'h100, 1'b1, 32'h200);

    // Two not-taken hit updates: counter 10 -> 01 -> 00.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b0; upd_target = 32'hDEAD;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("hit_ready", 32'(upd_ready), 32'd1);
      check("hit_set", 32'(ctr_set), 32'd1);
      check("hit_set_idx", 32'(ctr_set_index), 32'd0);
      check("hit_fb", 32'(ctr_feedback), 32'd0);
      check("hit_noreset", 32'(ctr_reset), 32'd0);
      step();
    end
    upd_valid = 1'b0;
    lookup(32'h100, 1'b0, 32'h200);

    // Not-taken miss: single-cycle accept, no table activity.
    upd_valid = 1'b1; upd_pc = 32'h700; upd_taken = 1'b0;
    #1;
    check("nt_ready", 32'(upd_ready), 32'd1);
    check("nt_noset", 32'(ctr_set), 32'd0);
    step();
    upd_valid = 1'b0;
    #1;
    check("nt_ready_after", 32'(upd_ready), 32'd1);
    check("nt_noreset", 32'(ctr_reset), 32'd0);
    lookup(32'h700, 1'b0, 32'h0);

    // Fill remaining slots, then replace via pointer.
    alloc(32'h200, 32'h1200, 8'd1);
    alloc(32'h300, 32'h1300, 8'd2);
    alloc(32'h400, 32'h1400, 8'd3);
    alloc(32'h500, 32'h1500, 8'd0);
    alloc(32'h600, 32'h1600, 8'd1);
    lookup(32'h100, 1'b0, 32'h0);
    lookup(32'h500, 1'b1, 32'h1500);

    // Taken hit overwrites target; counter 10 -> 11.
    upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'hABC;
    #1;
    check("thit_set_idx", 32'(ctr_set_index), 32'd2);
    check("thit_fb", 32'(ctr_feedback), 32'd1);
    step();
    upd_valid = 1'b0;
    lookup(32'h300, 1'b1, 32'hABC);

    // Pointer continues 2, 3, then wraps to 0.
    alloc(32'h800, 32'h1800, 8'd2);
    alloc(32'h900, 32'h1900, 8'd3);
    alloc(32'hA00, 32'h1A00, 8'd0);

    // Same-cycle lookup and allocating update: lookup sees old state.
    lookup_valid = 1'b1; lookup_pc = 32'hB00;
    upd_valid = 1'b1; upd_pc = 32'hB00; upd_taken = 1'b1; upd_target = 32'h1B00;
    step();
    upd_valid = 1'b0;
    lookup_pc = 32'h900;
    #1;
    check("rbw_pred_taken", 32'(pred_taken), 32'd0);
    check("rbw_pred_target", pred_target, 32'h0);
    check("rbw_alloc_idx", 32'(ctr_reset_index), 32'd1);
    step();
    lookup_valid = 1'b0;
    #1;
    check("alloc_lookup_tgt", pred_target, 32'h1900);
    step();
    lookup(32'hB00, 1'b1, 32'h1B00);

    // Reset while in ALLOC abandons the allocation.
    upd_valid = 1'b1; upd_pc = 32'hC00; upd_taken = 1'b1; upd_target = 32'h1C00;
    step();
    upd_valid = 1'b0;
    #1;
    check("r6_in_alloc", 32'(ctr_reset), 32'd1);
    reset = 1'b1;
    #1;
    check("r6_reset_drop", 32'(ctr_reset), 32'd0);
    check("r6_ready_rst", 32'(upd_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("r6_idle_ready", 32'(upd_ready), 32'd1);
    check("r6_noset", 32'(ctr_set), 32'd0);
    step();
    check("r6_noset2", 32'(ctr_set), 32'd0);
    lookup(32'hC00, 1'b0, 32'h0);
    lookup(32'h500, 1'b0, 32'h0);
    lookup(32'h900, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
